// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the integer ALU and its front-end controller.
//   XLEN        operand / result width
//   ALU_OP_W    opcode bus width; bits [8:0] are a one-hot operation select,
//               bits [13:9] are reserved and must be zero
//   OP_*        bit index of each operation inside the one-hot field
//   alu_op_legal() true when the opcode selects exactly one operation
package alu_pkg;

   localparam int XLEN        = 32;
   localparam int ALU_OP_W    = 14;
   localparam int OP_ONEHOT_W = 9;

   localparam int OP_ADD = 0;
   localparam int OP_IMM = 1;
   localparam int OP_OR  = 2;
   localparam int OP_SUB = 3;
   localparam int OP_XOR = 4;
   localparam int OP_SRA = 5;
   localparam int OP_AND = 6;
   localparam int OP_SLL = 7;
   localparam int OP_SRL = 8;

   function automatic logic alu_op_legal(input logic [ALU_OP_W-1:0] op);
      return (op[ALU_OP_W-1:OP_ONEHOT_W] == '0) && $onehot(op[OP_ONEHOT_W-1:0]);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with its own priority pointer.
//   clk, rst_n   clock, async active-low reset (pointer clears to 0)
//   req          request bits, one per requester
//   enable       when low no grant is produced
//   grant        one-hot grant (all zero when nothing is granted)
//   grant_idx    encoded index of the granted requester
//   grant_valid  a grant is issued this cycle; the pointer advances past it
// Every grant is taken as accepted, so the pointer moves to winner+1 on any
// cycle with grant_valid and holds otherwise.
module rr_arbiter #(
   parameter int NREQ = 2,
   parameter int ID_W = $clog2(NREQ)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   input  logic            enable,
   output logic [NREQ-1:0] grant,
   output logic [ID_W-1:0] grant_idx,
   output logic            grant_valid
);

   logic [ID_W-1:0] ptr;

   // Winner is the requester with the smallest circular distance from ptr.
   always_comb begin : pick
      int best;
      int d;
      best        = NREQ;
      d           = 0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         d = i - int'(ptr);
         if (d < 0) d = d + NREQ;
         if (enable && req[i] && (d < best)) begin
            best        = d;
            grant_idx   = ID_W'(i);
            grant_valid = 1'b1;
         end
      end
   end

   always_comb begin
      grant = '0;
      for (int i = 0; i < NREQ; i++) begin
         grant[i] = grant_valid && (grant_idx == ID_W'(i));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (grant_valid) begin
         ptr <= (grant_idx == ID_W'(NREQ-1)) ? '0 : grant_idx + ID_W'(1);
      end
   end

endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one combinational ALU between NREQ issue requesters.
//   clk, rst_n      clock, async active-low reset
//   flush           kills the response entry and this cycle's grant
//   req_valid/ready per-requester request handshake (ready is the grant)
//   req_op/src1/src2/tag  per-requester payload, packed requester-major
//   alu_op/src1/src2      drive into the shared ALU (zero when idle/illegal)
//   alu_result            combinational ALU result
//   resp_valid/ready      response handshake toward writeback
//   resp_id/tag/result/err captured response fields
//
// Handshakes: a transfer happens on a rising edge where valid & ready are
// both high. Producers hold valid and payload stable until the transfer and
// never derive valid from ready; ready may depend on valid. The response
// fields are stable while resp_valid & !resp_ready.
module alu_share_ctrl
   import alu_pkg::*;
#(
   parameter int NREQ  = 2,
   parameter int TAG_W = 4,
   parameter int ID_W  = $clog2(NREQ)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ*ALU_OP_W-1:0] req_op,
   input  logic [NREQ*XLEN-1:0]     req_src1,
   input  logic [NREQ*XLEN-1:0]     req_src2,
   input  logic [NREQ*TAG_W-1:0]    req_tag,
   output logic [ALU_OP_W-1:0]      alu_op,
   output logic [XLEN-1:0]          alu_src1,
   output logic [XLEN-1:0]          alu_src2,
   input  logic [XLEN-1:0]          alu_result,
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic [ID_W-1:0]          resp_id,
   output logic [TAG_W-1:0]         resp_tag,
   output logic [XLEN-1:0]          resp_result,
   output logic                     resp_err
);

   logic                slot_free;
   logic                arb_en;
   logic [NREQ-1:0]     grant;
   logic [ID_W-1:0]     grant_idx;
   logic                grant_valid;
   logic [ALU_OP_W-1:0] win_op;
   logic [XLEN-1:0]     win_src1;
   logic [XLEN-1:0]     win_src2;
   logic [TAG_W-1:0]    win_tag;
   logic                win_legal;
   logic                drive_alu;

   // The single response entry can take a new result when it is empty or
   // being drained in the same cycle.
   assign slot_free = !resp_valid || resp_ready;
   assign arb_en    = slot_free && !flush;

   rr_arbiter #(
      .NREQ (NREQ),
      .ID_W (ID_W)
   ) u_arb (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req_valid),
      .enable      (arb_en),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   always_comb begin
      win_op   = '0;
      win_src1 = '0;
      win_src2 = '0;
      win_tag  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            win_op   = req_op[i*ALU_OP_W +: ALU_OP_W];
            win_src1 = req_src1[i*XLEN +: XLEN];
            win_src2 = req_src2[i*XLEN +: XLEN];
            win_tag  = req_tag[i*TAG_W +: TAG_W];
         end
      end
   end

   assign win_legal = alu_op_legal(win_op);

   // rst_n only gates the outputs here, keeping it off every flop's data path;
   // the registers are held in reset anyway while it is low.
   assign drive_alu = grant_valid && win_legal && rst_n;
   assign req_ready = grant & {NREQ{rst_n}};
   assign alu_op    = drive_alu ? win_op   : '0;
   assign alu_src1  = drive_alu ? win_src1 : '0;
   assign alu_src2  = drive_alu ? win_src2 : '0;

   // Flush wins over drain; a grant cannot coexist with flush (arb_en).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_valid  <= 1'b0;
         resp_id     <= '0;
         resp_tag    <= '0;
         resp_result <= '0;
         resp_err    <= 1'b0;
      end else if (flush) begin
         resp_valid <= 1'b0;
      end else if (grant_valid) begin
         resp_valid  <= 1'b1;
         resp_id     <= grant_idx;
         resp_tag    <= win_tag;
         resp_result <= win_legal ? alu_result : '0;
         resp_err    <= !win_legal;
      end else if (resp_ready) begin
         resp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_share_ctrl.sv
module tb_alu_share_ctrl;
   import alu_pkg::*;

   localparam int NREQ  = 2;
   localparam int TAG_W = 4;
   localparam int ID_W  = 1;
   localparam int W     = ID_W + TAG_W + XLEN + 1;

   logic clk = 1'b0;
   logic rst_n;
   logic flush;
   logic resp_ready;

   logic [NREQ-1:0]          req_valid;
   logic [NREQ-1:0]          req_ready;
   logic [NREQ*ALU_OP_W-1:0] req_op;
   logic [NREQ*XLEN-1:0]     req_src1;
   logic [NREQ*XLEN-1:0]     req_src2;
   logic [NREQ*TAG_W-1:0]    req_tag;
   logic [ALU_OP_W-1:0]      alu_op;
   logic [XLEN-1:0]          alu_src1;
   logic [XLEN-1:0]          alu_src2;
   logic [XLEN-1:0]          alu_result;
   logic                     resp_valid;
   logic [ID_W-1:0]          resp_id;
   logic [TAG_W-1:0]         resp_tag;
   logic [XLEN-1:0]          resp_result;
   logic                     resp_err;

   // requester-side state
   logic                r_valid [NREQ];
   logic [ALU_OP_W-1:0] r_op    [NREQ];
   logic [XLEN-1:0]     r_src1  [NREQ];
   logic [XLEN-1:0]     r_src2  [NREQ];
   logic [TAG_W-1:0]    r_tag   [NREQ];

   // model state
   logic [W-1:0] exp_q[$];
   logic         m_valid;
   int           m_ptr;
   int           last_grant;
   int           n_cmp;
   int           n_err;

   alu_share_ctrl #(.NREQ(NREQ), .TAG_W(TAG_W), .ID_W(ID_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_op      (req_op),
      .req_src1    (req_src1),
      .req_src2    (req_src2),
      .req_tag     (req_tag),
      .alu_op      (alu_op),
      .alu_src1    (alu_src1),
      .alu_src2    (alu_src2),
      .alu_result  (alu_result),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_id     (resp_id),
      .resp_tag    (resp_tag),
      .resp_result (resp_result),
      .resp_err    (resp_err)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- reference ALU / legality ----------------
   function automatic logic legal_ref(input logic [ALU_OP_W-1:0] op);
      return (op[13:9] == 5'd0) && ($countones(op[8:0]) == 1);
   endfunction

   function automatic logic [XLEN-1:0] ref_alu(input logic [ALU_OP_W-1:0] op,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
      logic [XLEN-1:0] r;
      r = '0;
      if (op[13:9] == 5'd0) begin
         case (op[8:0])
            9'h001:  r = a + b;
            9'h002:  r = b;
            9'h004:  r = a | b;
            9'h008:  r = a - b;
            9'h010:  r = a ^ b;
            9'h020:  r = XLEN'($signed(a) >>> b[4:0]);
            9'h040:  r = a & b;
            9'h080:  r = a << b[4:0];
            9'h100:  r = a >> b[4:0];
            default: r = '0;
         endcase
      end
      return r;
   endfunction

   // the shared ALU seen by the DUT
   always_comb alu_result = ref_alu(alu_op, alu_src1, alu_src2);

   always_comb begin
      req_valid = '0;
      req_op    = '0;
      req_src1  = '0;
      req_src2  = '0;
      req_tag   = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i]                     = r_valid[i];
         req_op[i*ALU_OP_W +: ALU_OP_W]   = r_op[i];
         req_src1[i*XLEN +: XLEN]         = r_src1[i];
         req_src2[i*XLEN +: XLEN]         = r_src2[i];
         req_tag[i*TAG_W +: TAG_W]        = r_tag[i];
      end
   end

   // ---------------- check ----------------
   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_req(input int i, input logic [ALU_OP_W-1:0] op,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [TAG_W-1:0] tag);
      r_valid[i] = 1'b1;
      r_op[i]    = op;
      r_src1[i]  = a;
      r_src2[i]  = b;
      r_tag[i]   = tag;
   endtask

   function automatic logic [ALU_OP_W-1:0] rand_op();
      logic [ALU_OP_W-1:0] op;
      if ($urandom_range(0, 9) == 0) op = ALU_OP_W'($urandom_range(0, 16383));
      else                           op = ALU_OP_W'(1) << $urandom_range(0, 8);
      return op;
   endfunction

   task automatic set_rand_req(input int i);
      set_req(i, rand_op(), $urandom, $urandom, TAG_W'($urandom_range(0, 15)));
   endtask

   // Sample at the falling edge, compare against the model, advance the model.
   task automatic sample();
      int win;
      logic [NREQ-1:0]     exp_rdy;
      logic [ALU_OP_W-1:0] exp_op;
      logic [XLEN-1:0]     e1;
      logic [XLEN-1:0]     e2;
      logic [W-1:0]        e;
      @(negedge clk);
      win = -1;
      if ((!m_valid || resp_ready) && !flush) begin
         for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NREQ;
            if (win < 0 && r_valid[idx]) win = idx;
         end
      end
      exp_rdy = '0;
      exp_op  = '0;
      e1      = '0;
      e2      = '0;
      if (win >= 0) begin
         exp_rdy[win] = 1'b1;
         if (legal_ref(r_op[win])) begin
            exp_op = r_op[win];
            e1     = r_src1[win];
            e2     = r_src2[win];
         end
      end
      check_eq("req_ready", 64'(req_ready), 64'(exp_rdy));
      check_eq("alu_op", 64'(alu_op), 64'(exp_op));
      check_eq("alu_src1", 64'(alu_src1), 64'(e1));
      check_eq("alu_src2", 64'(alu_src2), 64'(e2));
      check_eq("resp_valid", 64'(resp_valid), 64'(m_valid));
      if (m_valid && exp_q.size() > 0) begin
         e = exp_q[0];
         check_eq("resp_id", 64'(resp_id), 64'(e[W-1 -: ID_W]));
         check_eq("resp_tag", 64'(resp_tag), 64'(e[W-1-ID_W -: TAG_W]));
         check_eq("resp_result", 64'(resp_result), 64'(e[XLEN:1]));
         check_eq("resp_err", 64'(resp_err), 64'(e[0]));
      end
      last_grant = win;
      if (flush) begin
         if (m_valid && exp_q.size() > 0) void'(exp_q.pop_front());
         m_valid = 1'b0;
      end else begin
         if (m_valid && resp_ready) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            m_valid = 1'b0;
         end
         if (win >= 0) begin
            exp_q.push_back({ID_W'(win), r_tag[win],
                             ref_alu(r_op[win], r_src1[win], r_src2[win]),
                             !legal_ref(r_op[win])});
            m_valid = 1'b1;
            m_ptr   = (win + 1) % NREQ;
         end
      end
   endtask

   // Cross the rising edge; an accepted requester drops its request.
   task automatic advance();
      @(posedge clk);
      #1;
      if (last_grant >= 0) r_valid[last_grant] = 1'b0;
      last_grant = -1;
   endtask

   task automatic drain_all();
      int n;
      n = 0;
      while ((r_valid[0] || r_valid[1] || m_valid) && n < 20) begin
         sample();
         advance();
         n++;
      end
      check_eq("drain_done", 64'(r_valid[0] || r_valid[1] || m_valid), 64'd0);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int glog[$];
      int pat[6];
      int n_resp;
      pat = '{0, 1, 0, 1, 0, 1};
      n_cmp = 0;
      n_err = 0;
      m_valid = 1'b0;
      m_ptr = 0;
      last_grant = -1;
      for (int i = 0; i < NREQ; i++) begin
         r_valid[i] = 1'b0;
         r_op[i]    = '0;
         r_src1[i]  = '0;
         r_src2[i]  = '0;
         r_tag[i]   = '0;
      end
      rst_n      = 1'b0;
      flush      = 1'b0;
      resp_ready = 1'b1;

      // reset state, with a request already pending
      set_req(0, ALU_OP_W'(1) << OP_ADD, 32'd5, 32'd7, 4'd3);
      #2;
      check_eq("rst_req_ready", 64'(req_ready), 64'd0);
      check_eq("rst_alu_op", 64'(alu_op), 64'd0);
      check_eq("rst_resp_valid", 64'(resp_valid), 64'd0);
      check_eq("rst_resp_fields", {resp_result, 31'd0, resp_err}, 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // single request: ADD 5+7 tag 3
      sample();
      check_eq("t1_ready", 64'(req_ready), 64'd1);
      advance();
      sample();
      check_eq("t1_valid", 64'(resp_valid), 64'd1);
      check_eq("t1_result", 64'(resp_result), 64'd12);
      check_eq("t1_id", 64'(resp_id), 64'd0);
      check_eq("t1_tag", 64'(resp_tag), 64'd3);
      check_eq("t1_err", 64'(resp_err), 64'd0);
      advance();

      // lone request from 1 moves the pointer back to 0
      set_req(1, ALU_OP_W'(1) << OP_OR, 32'hf0, 32'h0f, 4'd5);
      sample();
      advance();
      sample();
      check_eq("t1b_result", 64'(resp_result), 64'hff);
      advance();

      // fairness: both valid for 6 cycles
      n_resp = 0;
      for (int k = 0; k < 6; k++) begin
         for (int i = 0; i < NREQ; i++) if (!r_valid[i]) set_rand_req(i);
         sample();
         if (k > 0 && resp_valid) n_resp++;
         glog.push_back(last_grant);
         advance();
      end
      for (int k = 0; k < 6; k++) check_eq($sformatf("fair_grant%0d", k), 64'(glog[k]), 64'(pat[k]));
      sample();
      if (resp_valid) n_resp++;
      advance();
      check_eq("fair_b2b_resps", 64'(n_resp), 64'd6);
      drain_all();

      // backpressure holding SUB 10-3
      set_req(0, ALU_OP_W'(1) << OP_SUB, 32'd10, 32'd3, 4'd9);
      sample();
      advance();
      resp_ready = 1'b0;
      set_rand_req(0);
      set_rand_req(1);
      for (int k = 0; k < 3; k++) begin
         sample();
         check_eq("bp_ready", 64'(req_ready), 64'd0);
         check_eq("bp_result", 64'(resp_result), 64'd7);
         check_eq("bp_tag", 64'(resp_tag), 64'd9);
         advance();
      end
      resp_ready = 1'b1;
      sample();
      check_eq("bp_release_grant", 64'(|req_ready), 64'd1);
      advance();
      drain_all();

      // illegal opcodes from requester 1
      set_req(1, 14'h0005, 32'd1, 32'd2, 4'd6);
      sample();
      check_eq("ill1_alu_op", 64'(alu_op), 64'd0);
      check_eq("ill1_ready", 64'(req_ready), 64'd2);
      advance();
      set_req(1, 14'h0200, 32'd3, 32'd4, 4'd7);
      sample();
      check_eq("ill2_alu_op", 64'(alu_op), 64'd0);
      check_eq("ill1_err", 64'(resp_err), 64'd1);
      check_eq("ill1_result", 64'(resp_result), 64'd0);
      check_eq("ill1_id", 64'(resp_id), 64'd1);
      advance();
      sample();
      check_eq("ill2_err", 64'(resp_err), 64'd1);
      check_eq("ill2_result", 64'(resp_result), 64'd0);
      check_eq("ill2_id", 64'(resp_id), 64'd1);
      advance();
      drain_all();

      // flush with a pending response and both requesters valid
      set_req(0, ALU_OP_W'(1) << OP_XOR, 32'h55, 32'hff, 4'd1);
      sample();
      advance();
      set_rand_req(0);
      set_rand_req(1);
      flush = 1'b1;
      sample();
      check_eq("flush_ready", 64'(req_ready), 64'd0);
      advance();
      flush = 1'b0;
      sample();
      check_eq("flush_valid", 64'(resp_valid), 64'd0);
      advance();

      // reset mid-stream
      resp_ready = 1'b0;
      for (int i = 0; i < NREQ; i++) if (!r_valid[i]) set_rand_req(i);
      #1 rst_n = 1'b0;
      #1;
      check_eq("mrst_req_ready", 64'(req_ready), 64'd0);
      check_eq("mrst_alu", {alu_op, 18'd0, alu_src1}, 64'd0);
      check_eq("mrst_alu_src2", 64'(alu_src2), 64'd0);
      check_eq("mrst_resp_valid", 64'(resp_valid), 64'd0);
      check_eq("mrst_resp_fields", {resp_result, 26'd0, resp_tag, resp_id, resp_err}, 64'd0);
      m_valid = 1'b0;
      m_ptr   = 0;
      exp_q.delete();
      last_grant = -1;
      @(posedge clk);
      #1 rst_n = 1'b1;
      resp_ready = 1'b1;
      sample();
      check_eq("mrst_first_grant", 64'(req_ready), 64'd1);
      advance();

      // random traffic
      for (int c = 0; c < 300; c++) begin
         for (int i = 0; i < NREQ; i++)
            if (!r_valid[i] && $urandom_range(0, 2) != 0) set_rand_req(i);
         resp_ready = ($urandom_range(0, 3) != 0);
         flush      = ($urandom_range(0, 19) == 0);
         sample();
         advance();
      end
      flush      = 1'b0;
      resp_ready = 1'b1;
      drain_all();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Shares the single combinational integer ALU between `NREQ` issue requesters, such as the main execute slot and the branch/address slot. Each cycle it:
- arbitrates round-robin among requesters;
- drives the winner's one-hot opcode and operands into the ALU;
- checks opcode legality;
- captures the result, with requester id and tag, into a one-entry response register under valid/ready flow control.

It sits between issue and writeback in the backend, directly in front of the ALU.

## Interface
- `NREQ`, 2: number of requesters (2..4).
- `TAG_W`, 4: width of the opaque tag returned with each result.
- `ID_W`, $clog2(NREQ): requester id width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `flush` in 1: synchronous kill of the response entry and of this cycle's grant.
- `req_valid` in NREQ: request present, one bit per requester.
- `req_ready` out NREQ: grant; a request is accepted when `req_valid[i] & req_ready[i]`.
- `req_op` in NREQ*14: per-requester ALU opcode, one-hot in bits [8:0].
- `req_src1`, `req_src2` in NREQ*32: per-requester operands.
- `req_tag` in NREQ*TAG_W: per-requester tag.
- `alu_op` out 14: opcode to the ALU.
- `alu_src1`, `alu_src2` out 32: operands to the ALU.
- `alu_result` in 32: combinational result from the ALU.
- `resp_valid` out 1: response register holds a result.
- `resp_ready` in 1: consumer accepts the response.
- `resp_id` out ID_W: id of the requester that produced the result.
- `resp_tag` out TAG_W: tag of that request.
- `resp_result` out 32: ALU result.
- `resp_err` out 1: the opcode was illegal; `resp_result` is 0.

## Operation
- **Slot availability:** `slot_free = !resp_valid | resp_ready`.
- **Arbitration:** round-robin starting at pointer `rr_ptr`.
  - The lowest index at or after `rr_ptr` (wrapping) with `req_valid` set wins.
  - Exactly one `req_ready` bit is high, and only when `slot_free & !flush`; otherwise all bits are 0.
  - `req_ready` may depend on `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- **Pointer update:** on an accepted grant to requester `g`, `rr_ptr` becomes `(g+1) mod NREQ`. With no grant, `rr_ptr` holds.
- **Opcode legality:** an opcode is legal iff exactly one of bits [8:0] is set and bits [13:9] are zero.
- **ALU drive:**
  - With a grant and a legal opcode, `alu_op`/`alu_src1`/`alu_src2` are the winner's fields.
  - Otherwise they are driven to all-zero, so the ALU is idle and produces 0.
- **Capture on accept:**
  - `resp_valid <= 1`, `resp_id <= g`, `resp_tag <= req_tag[g]`.
  - Legal opcode: `resp_result <= alu_result`, `resp_err <= 0`.
  - Illegal opcode: `resp_result <= 0`, `resp_err <= 1`.
- **Drain:** with `resp_valid & resp_ready` and no new accept, `resp_valid <= 0`. The data fields hold their last values.
- **Flush:** `resp_valid <= 0` and no grant is issued that cycle. A pending `resp_ready` in that cycle is ignored.
- **Requester stability:** requesters hold valid and payload until accepted.

## Timing
- **Reset:** async assert and synchronous release. All of the following clear to 0:
  - `resp_valid`, `resp_id`, `resp_tag`, `resp_result`, `resp_err`;
  - `rr_ptr`, so requester 0 has first priority.
- **Outputs during reset:** `req_ready` and `alu_*` are 0 while `rst_n` is low.
- **Latency:** accept at edge N puts `resp_valid` high after edge N, with the result visible in cycle N+1. This is one cycle, with a single combinational ALU pass per cycle.
- **Throughput:** one result per cycle when `resp_ready` is held high. Back-to-back accepts with a simultaneous drain are required.
- **Backpressure:** `resp_valid & !resp_ready` forces all `req_ready` low. The response fields hold stable until drained.
- **Reset mid-operation:** in-flight data is dropped. The first grant after release goes to the lowest-indexed valid requester.

## Structure
- **Shared package `alu_pkg`:**
  - `XLEN=32`, `ALU_OP_W=14`.
  - Named opcode bit indices: ADD=0, IMM=1, OR=2, SUB=3, XOR=4, SRA=5, AND=6, SLL=7, SRL=8.
  - An `alu_op_legal` function.
- **Sub-module `rr_arbiter`:** parameterized by NREQ, with inputs req/enable, outputs one-hot grant plus encoded index, and owning the pointer register. The controller instantiates it once and owns the response register and muxing.

## Test plan
- **Single request:** after reset, req 0 issues ADD 5+7, tag 3, `resp_ready`=1. Required:
  - `req_ready[0]`=1 in the same cycle;
  - next cycle `resp_valid`=1, `resp_result`=12, `resp_id`=0, `resp_tag`=3, `resp_err`=0.
- **Fairness:** both requesters hold `req_valid`=1 for 6 cycles with `resp_ready`=1. Required: grants alternate 0,1,0,1,0,1 and 6 responses come back-to-back.
- **Backpressure:** `resp_ready`=0 for 3 cycles while both requesters are valid. Required:
  - `req_ready`=0 throughout;
  - the response fields hold a SUB result of 10-3=7;
  - on release, the result drains and the next grant occurs in the same cycle.
- **Illegal opcode:** req 1 issues opcode 14'h0005 (two bits set), then 14'h0200. Required for each: `alu_op`=0 driven to the ALU, `resp_err`=1, `resp_result`=0, `resp_id`=1.
- **Flush and reset:**
  - `flush` while `resp_valid`=1 and both requesters valid → next cycle `resp_valid`=0 with no grant in the flush cycle.
  - `rst_n` low mid-stream → all outputs 0 immediately; after release, req 0 wins first.
